// File: rtl/demux_route_buf_if.sv
// Producer/consumer bundle for demux_route_buf.
// master drives words and consumer readies; slave is the router.
interface demux_route_buf_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
);
  logic [WIDTH-1:0]        in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_bcast;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;

  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/demux_route_buf.sv
// Registered 1-to-NUM_CH demux with one-entry buffer per channel.
// Out-of-range selects are sunk, flagged and counted.
module demux_route_buf #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  demux_route_buf_if.slave bus,
  output logic             sel_err,
  output logic [7:0]       err_cnt
);
  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(NUM_CH);

  logic [NUM_CH-1:0]       full;
  logic [NUM_CH-1:0]       pop;
  logic [NUM_CH-1:0]       free;
  logic [NUM_CH-1:0]       hit;
  logic [NUM_CH-1:0]       wr;
  logic [WIDTH-1:0]        bufq [NUM_CH];
  logic [NUM_CH*WIDTH-1:0] od;
  logic                    in_rng;
  logic                    rdy;
  logic                    acc;
  logic                    drop;

  assign in_rng = {1'b0, bus.in_sel} < NCH;
  assign pop    = full & bus.out_ready;
  assign free   = ~full | pop;

  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_CH; k++)
      hit[k] = bus.in_bcast | (bus.in_sel == SEL_W'(k));
  end

  always_comb begin
    if (bus.in_bcast)
      rdy = &free;
    else if (in_rng)
      rdy = |(free & hit);
    else
      rdy = 1'b1;
  end

  assign acc  = bus.in_valid & rdy;
  assign drop = acc & ~bus.in_bcast & ~in_rng;
  assign wr   = acc ? hit : '0;

  assign bus.in_ready  = rdy;
  assign bus.out_valid = full;

  always_comb begin
    od = '0;
    for (int k = 0; k < NUM_CH; k++)
      od[k*WIDTH +: WIDTH] = bufq[k];
  end

  assign bus.out_data = od;

  // a popped channel with no refill clears its data to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
      for (int k = 0; k < NUM_CH; k++)
        bufq[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr[k]) begin
          bufq[k] <= bus.in_data;
          full[k] <= 1'b1;
        end else if (pop[k]) begin
          bufq[k] <= '0;
          full[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      sel_err <= drop;
      if (drop && err_cnt != 8'hff)
        err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_demux_route_buf.sv
// Bench for demux_route_buf: default 4x8 instance and a 5x32 instance
// with out-of-range selects, both checked against a queue model.
module tb_demux_route_buf;
  logic clk;
  logic rst_n;
  logic sel_err_a, sel_err_b;
  logic [7:0] err_cnt_a, err_cnt_b;
  int n_cmp, n_err;
  bit r;

  demux_route_buf_if ifa ();
  demux_route_buf_if #(.WIDTH(32), .NUM_CH(5), .SEL_W(3)) ifb ();

  demux_route_buf u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa),
    .sel_err(sel_err_a), .err_cnt(err_cnt_a)
  );

  demux_route_buf #(.WIDTH(32), .NUM_CH(5), .SEL_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb),
    .sel_err(sel_err_b), .err_cnt(err_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // per-instance, per-channel contents (capacity one), drop state
  logic [31:0] mq [2][8][$];
  bit  edrop [2];
  int  ecnt [2];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int id = 0; id < 2; id++) begin
      for (int k = 0; k < 8; k++) mq[id][k].delete();
      edrop[id] = 1'b0;
      ecnt[id] = 0;
    end
  endtask

  task automatic model_step(
    input int id, input int nch, input int w,
    input bit v, input int sel, input bit bc,
    input logic [31:0] d, input logic [7:0] ordy,
    input logic rdy_o, input logic [7:0] ov_o,
    input logic [255:0] od_o, input logic se_o, input logic [7:0] ec_o
  );
    bit rdy;
    bit acc;
    logic [7:0] ov;
    logic [31:0] msk;
    logic [31:0] ed;
    logic [31:0] got;
    msk = (w == 32) ? 32'hffff_ffff : 32'h0000_00ff;
    rdy = 1'b1;
    if (bc) begin
      for (int k = 0; k < nch; k++)
        if (mq[id][k].size() != 0 && !ordy[k]) rdy = 1'b0;
    end else if (sel < nch) begin
      rdy = (mq[id][sel].size() == 0) || ordy[sel];
    end
    chk($sformatf("ready%0d", id), 64'(rdy_o), 64'(rdy));
    ov = '0;
    for (int k = 0; k < nch; k++) ov[k] = mq[id][k].size() != 0;
    chk($sformatf("valid%0d", id), 64'(ov_o), 64'(ov));
    for (int k = 0; k < nch; k++) begin
      ed  = (mq[id][k].size() != 0) ? mq[id][k][0] : 32'h0;
      got = 32'((od_o >> (k*w)) & 256'(msk));
      chk($sformatf("data%0d_ch%0d", id, k), 64'(got), 64'(ed));
    end
    chk($sformatf("selerr%0d", id), 64'(se_o), 64'(edrop[id]));
    chk($sformatf("errcnt%0d", id), 64'(ec_o),
        64'((ecnt[id] > 255) ? 255 : ecnt[id]));
    acc = v && rdy;
    for (int k = 0; k < nch; k++)
      if (mq[id][k].size() != 0 && ordy[k]) void'(mq[id][k].pop_front());
    edrop[id] = 1'b0;
    if (acc) begin
      if (bc) begin
        for (int k = 0; k < nch; k++) mq[id][k].push_back(d & msk);
      end else if (sel < nch) begin
        mq[id][sel].push_back(d & msk);
      end else begin
        edrop[id] = 1'b1;
        ecnt[id]++;
      end
    end
  endtask

  task automatic step_a(input bit v, input int sel, input bit bc,
                        input logic [7:0] d, input logic [3:0] ordy,
                        output bit rdy);
    @(negedge clk);
    ifa.in_valid  = v;
    ifa.in_sel    = 2'(sel);
    ifa.in_bcast  = bc;
    ifa.in_data   = d;
    ifa.out_ready = ordy;
    #1;
    rdy = ifa.in_ready;
    model_step(0, 4, 8, v, sel, bc, 32'(d), 8'(ordy), ifa.in_ready,
               8'(ifa.out_valid), 256'(ifa.out_data), sel_err_a, err_cnt_a);
  endtask

  task automatic step_b(input bit v, input int sel, input bit bc,
                        input logic [31:0] d, input logic [4:0] ordy,
                        output bit rdy);
    @(negedge clk);
    ifb.in_valid  = v;
    ifb.in_sel    = 3'(sel);
    ifb.in_bcast  = bc;
    ifb.in_data   = d;
    ifb.out_ready = ordy;
    #1;
    rdy = ifb.in_ready;
    model_step(1, 5, 32, v, sel, bc, d, 8'(ordy), ifb.in_ready,
               8'(ifb.out_valid), 256'(ifb.out_data), sel_err_b, err_cnt_b);
  endtask

  initial begin
    bit pv, pr, v, bc;
    int sel;
    logic [31:0] d;
    n_cmp = 0;
    n_err = 0;
    mreset();
    rst_n = 1'b0;
    ifa.in_valid = 0; ifa.in_sel = 0; ifa.in_bcast = 0;
    ifa.in_data = 0; ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.in_sel = 0; ifb.in_bcast = 0;
    ifb.in_data = 0; ifb.out_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ov_a", 64'(ifa.out_valid), 64'h0);
    chk("rst_od_a", 64'(ifa.out_data), 64'h0);
    chk("rst_rdy_a", 64'(ifa.in_ready), 64'h1);
    chk("rst_ov_b", 64'(ifb.out_valid), 64'h0);
    chk("rst_ec_b", 64'(err_cnt_b), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // routed word held until consumer 2 drains
    step_a(1, 2, 0, 8'hA5, 4'h0, r);
    step_a(1, 2, 0, 8'h5A, 4'h0, r);
    chk("rt_ov", 64'(ifa.out_valid), 64'h4);
    chk("rt_od", 64'(ifa.out_data), 64'h00A5_0000);
    chk("rt_stall", 64'(r), 64'h0);
    step_a(1, 2, 0, 8'h5A, 4'h0, r);
    chk("rt_stall2", 64'(r), 64'h0);
    step_a(1, 2, 0, 8'h5A, 4'h4, r);
    chk("rt_go", 64'(r), 64'h1);
    step_a(0, 0, 0, 8'h00, 4'h0, r);
    chk("rt_od2", 64'(ifa.out_data), 64'h005A_0000);
    step_a(0, 0, 0, 8'h00, 4'h4, r);
    step_a(0, 0, 0, 8'h00, 4'h0, r);
    chk("rt_empty", 64'(ifa.out_valid), 64'h0);

    // full-rate stream on channel 1
    for (int i = 1; i <= 16; i++) begin
      step_a(1, 1, 0, 8'(i), 4'h2, r);
      chk("b2b_rdy", 64'(r), 64'h1);
      if (i > 1) chk("b2b_data", 64'(ifa.out_data[15:8]), 64'(i-1));
    end
    step_a(0, 0, 0, 8'h00, 4'h2, r);
    chk("b2b_last", 64'(ifa.out_data[15:8]), 64'h10);
    step_a(0, 0, 0, 8'h00, 4'h0, r);

    // broadcast blocked by a full, stalled channel 3
    step_a(1, 3, 0, 8'h77, 4'h0, r);
    step_a(1, 0, 1, 8'h3C, 4'h0, r);
    chk("bc_stall", 64'(r), 64'h0);
    step_a(1, 0, 1, 8'h3C, 4'h0, r);
    chk("bc_nowrite", 64'(ifa.out_data), 64'h7700_0000);
    step_a(1, 0, 1, 8'h3C, 4'h8, r);
    chk("bc_go", 64'(r), 64'h1);
    step_a(0, 0, 0, 8'h00, 4'h0, r);
    chk("bc_ov", 64'(ifa.out_valid), 64'hF);
    chk("bc_od", 64'(ifa.out_data), 64'h3C3C_3C3C);

    // asynchronous reset with all buffers full
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov", 64'(ifa.out_valid), 64'h0);
    chk("arst_od", 64'(ifa.out_data), 64'h0);
    chk("arst_ec", 64'(err_cnt_a), 64'h0);
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
    step_a(0, 0, 0, 8'h00, 4'h0, r);
    chk("arst_rdy", 64'(r), 64'h1);
    chk("arst_ov2", 64'(ifa.out_valid), 64'h0);

    // random traffic, inputs held while stalled
    pv = 0; pr = 1; v = 0; sel = 0; bc = 0; d = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(pv && !pr)) begin
        v   = $urandom_range(0, 9) < 7;
        sel = $urandom_range(0, 3);
        bc  = $urandom_range(0, 5) == 0;
        d   = $urandom;
      end
      step_a(v, sel, bc, d[7:0], 4'($urandom), r);
      pv = v; pr = r;
    end
    step_a(0, 0, 0, 8'h00, 4'h0, r);

    pv = 0; pr = 1;
    for (int i = 0; i < 1500; i++) begin
      if (!(pv && !pr)) begin
        v   = $urandom_range(0, 9) < 7;
        sel = $urandom_range(0, 7);
        bc  = $urandom_range(0, 5) == 0;
        d   = $urandom;
      end
      step_b(v, sel, bc, d, 5'($urandom), r);
      pv = v; pr = r;
    end

    // sustained drops saturate the counter
    for (int i = 0; i < 300; i++) begin
      step_b(1, 7, 0, $urandom, 5'h1f, r);
      chk("drop_rdy", 64'(r), 64'h1);
    end
    step_b(0, 0, 0, 32'h0, 5'h1f, r);
    chk("sat_cnt", 64'(err_cnt_b), 64'hFF);
    chk("sat_pulse", 64'(sel_err_b), 64'h1);
    chk("sat_ov", 64'(ifb.out_valid), 64'h0);
    step_b(0, 0, 0, 32'h0, 5'h00, r);
    chk("pulse_end", 64'(sel_err_b), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
